// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory-port and status signals around mem_port_arbiter.
// slave = arbiter view, master = environment (requesters + memory model) view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
);
  // I-side requester
  logic              i_req_i;
  logic              i_write_i;
  logic [ADDR_W-1:0] i_addr_i;
  logic [DATA_W-1:0] i_data_i;
  logic [DATA_W-1:0] i_data_o;
  logic              i_ack_o;

  // D-side requester
  logic              d_req_i;
  logic              d_write_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_data_i;
  logic [DATA_W-1:0] d_data_o;
  logic              d_ack_o;

  // Shared memory port
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [DATA_W-1:0] mem_data_i;
  logic              mem_ack_i;

  // Status
  logic [1:0]        grant_o;
  logic              err_o;

  modport slave (
    input  i_req_i, i_write_i, i_addr_i, i_data_i,
    input  d_req_i, d_write_i, d_addr_i, d_data_i,
    input  mem_data_i, mem_ack_i,
    output i_data_o, i_ack_o, d_data_o, d_ack_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    output grant_o, err_o
  );

  modport master (
    output i_req_i, i_write_i, i_addr_i, i_data_i,
    output d_req_i, d_write_i, d_addr_i, d_data_i,
    output mem_data_i, mem_ack_i,
    input  i_data_o, i_ack_o, d_data_o, d_ack_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    input  grant_o, err_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (I/D) arbiter for a single cache-line memory port with ack watchdog.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed D-side priority.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 256,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic              clk_i,
  input logic              rst_i,
  mem_port_arbiter_if.slave bus
);

  // State codes double as the one-hot owner (bit0 = I, bit1 = D).
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_BUSY_I = 2'b01,
    ST_BUSY_D = 2'b10
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [1:0]             side_req;
  logic [1:0]             side_write;
  logic [1:0][ADDR_W-1:0] side_addr;
  logic [1:0][DATA_W-1:0] side_wdata;
  logic [1:0]             side_ack;
  logic [1:0][DATA_W-1:0] side_rdata;

  logic [1:0] win;
  logic       win_d;
  logic [1:0] owner_oh;
  logic       busy;
  logic       timeout_hit;
  logic       done;

  logic              mem_enable_reg;
  logic              mem_write_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_data_reg;
  logic [1:0]        grant_reg;
  logic              err_reg;

  assign side_req   = {bus.d_req_i,   bus.i_req_i};
  assign side_write = {bus.d_write_i, bus.i_write_i};
  assign side_addr  = {bus.d_addr_i,  bus.i_addr_i};
  assign side_wdata = {bus.d_data_i,  bus.i_data_i};

  // ---------------- arbitration ----------------
`ifdef MEM_ARB_RR_EN
  // 0 = I was granted last, 1 = D was granted last; the other side wins a tie.
  logic last_grant_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_reg <= 1'b0;
    end else if (state_reg == ST_IDLE && |side_req) begin
      last_grant_reg <= win_d;
    end
  end
`endif

  always_comb begin
    win = side_req;
    if (&side_req) begin
`ifdef MEM_ARB_RR_EN
      win = last_grant_reg ? 2'b01 : 2'b10;
`else
      win = 2'b10;
`endif
    end
  end

  assign win_d = win[1];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|side_req) begin
          state_next = win_d ? ST_BUSY_D : ST_BUSY_I;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (done) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    owner_oh = 2'b00;
    case (state_reg)
      ST_BUSY_I: owner_oh = 2'b01;
      ST_BUSY_D: owner_oh = 2'b10;
      default:   owner_oh = 2'b00;
    endcase
  end

  assign busy = |owner_oh;
  assign done = busy && (bus.mem_ack_i || timeout_hit);

  // Only the owner sees an ack; an abort returns zero data.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_side
      assign side_ack[gi]   = done && owner_oh[gi];
      assign side_rdata[gi] = (owner_oh[gi] && bus.mem_ack_i) ? bus.mem_data_i : '0;
    end
  endgenerate

  assign bus.i_ack_o  = side_ack[0];
  assign bus.d_ack_o  = side_ack[1];
  assign bus.i_data_o = side_rdata[0];
  assign bus.d_data_o = side_rdata[1];

  // ---------------- watchdog ----------------
  generate
    if (TIMEOUT_CYC > 0) begin : g_wdog
      localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          cnt_reg <= '0;
        end else if (state_reg == ST_IDLE) begin
          cnt_reg <= '0;
        end else if (!done) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      // Ack in the same cycle takes precedence over the abort.
      assign timeout_hit = busy && !bus.mem_ack_i && (cnt_reg == CNT_LAST);
    end else begin : g_no_wdog
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // ---------------- memory port and status registers ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_enable_reg <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_addr_reg   <= '0;
      mem_data_reg   <= '0;
      grant_reg      <= 2'b00;
    end else if (state_reg == ST_IDLE && |side_req) begin
      mem_enable_reg <= 1'b1;
      mem_write_reg  <= side_write[win_d];
      mem_addr_reg   <= side_addr[win_d];
      mem_data_reg   <= side_wdata[win_d];
      grant_reg      <= win;
    end else if (done) begin
      mem_enable_reg <= 1'b0;
      grant_reg      <= 2'b00;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_reg <= 1'b0;
    end else if (timeout_hit) begin
      err_reg <= 1'b1;
    end
  end

  assign bus.mem_enable_o = mem_enable_reg;
  assign bus.mem_write_o  = mem_write_reg;
  assign bus.mem_addr_o   = mem_addr_reg;
  assign bus.mem_data_o   = mem_data_reg;
  assign bus.grant_o      = grant_reg;
  assign bus.err_o        = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter checked against a cycle-level transaction model.
// Honours MEM_ARB_RR_EN so the same bench covers both arbitration builds.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Model state: owner 0 = idle, 1 = I, 2 = D; busy_cnt counts BUSY cycles from 1.
  int owner, busy_cnt, latency, last_side, n_txn;
  bit m_err, m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  bit rq_req[2], rq_write[2], rq_cool[2];
  logic [AW-1:0] rq_addr[2];
  logic [DW-1:0] rq_data[2];
  logic ack_now;
  logic [DW-1:0] rdata;

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    owner = 0; busy_cnt = 0; latency = 0; last_side = 0; m_err = 0;
    m_write = 0; m_addr = '0; m_wdata = '0;
    ack_now = 0; rdata = '0;
    for (int s = 0; s < 2; s++) begin
      rq_req[s] = 0; rq_write[s] = 0; rq_cool[s] = 0; rq_addr[s] = '0; rq_data[s] = '0;
    end
  endtask

  task automatic drive_bus();
    bus.i_req_i = rq_req[0]; bus.i_write_i = rq_write[0];
    bus.i_addr_i = rq_addr[0]; bus.i_data_i = rq_data[0];
    bus.d_req_i = rq_req[1]; bus.d_write_i = rq_write[1];
    bus.d_addr_i = rq_addr[1]; bus.d_data_i = rq_data[1];
    bus.mem_ack_i = ack_now; bus.mem_data_i = rdata;
  endtask

  task automatic step();
    bit tmo;
    int w;
    @(posedge clk);
    #1;
    check("mem_enable", bus.mem_enable_o, owner != 0);
    check("grant", bus.grant_o, owner == 1 ? 2'b01 : (owner == 2 ? 2'b10 : 2'b00));
    check("err", bus.err_o, m_err);
    if (owner != 0) begin
      check("mem_write", bus.mem_write_o, m_write);
      check("mem_addr", bus.mem_addr_o, m_addr);
      check("mem_wdata", bus.mem_data_o, m_wdata);
    end
    // requesters: drop after ack, occasional mid-BUSY withdrawal, random new requests
    for (int s = 0; s < 2; s++) begin
      if (rq_cool[s]) begin
        rq_req[s] = 0; rq_cool[s] = 0;
      end else if (rq_req[s]) begin
        if (owner == s + 1 && $urandom_range(0, 15) == 0) rq_req[s] = 0;
      end else if (owner != s + 1 && $urandom_range(0, 2) == 0) begin
        rq_req[s] = 1; rq_write[s] = $urandom_range(0, 1);
        rq_addr[s] = $urandom; rq_data[s] = rand_line();
      end
    end
    ack_now = (owner != 0) ? (busy_cnt == latency) : ($urandom_range(0, 7) == 0);
    rdata = rand_line();
    drive_bus();
    #1;
    tmo = (owner != 0) && !ack_now && (busy_cnt == TO);
    check("i_ack", bus.i_ack_o, owner == 1 && (ack_now || tmo));
    check("d_ack", bus.d_ack_o, owner == 2 && (ack_now || tmo));
    check("i_data", bus.i_data_o, (owner == 1 && ack_now) ? rdata : '0);
    check("d_data", bus.d_data_o, (owner == 2 && ack_now) ? rdata : '0);
    if (owner != 0) begin
      if (ack_now || tmo) begin
        n_txn++;
        $display("txn %0d side=%s %s addr=%h cycles=%0d result=%s", n_txn,
                 owner == 1 ? "I" : "D", m_write ? "WR" : "RD", m_addr, busy_cnt,
                 ack_now ? "ack" : "timeout");
        if (tmo) m_err = 1;
        rq_cool[owner - 1] = 1;
        owner = 0;
      end else begin
        busy_cnt++;
      end
    end else if (rq_req[0] || rq_req[1]) begin
`ifdef MEM_ARB_RR_EN
      if (rq_req[0] && rq_req[1]) w = (last_side == 0) ? 1 : 0;
      else w = rq_req[1] ? 1 : 0;
`else
      w = rq_req[1] ? 1 : 0;
`endif
      owner = w + 1; last_side = w; busy_cnt = 1;
      latency = $urandom_range(1, TO + 2);
      m_write = rq_write[w]; m_addr = rq_addr[w]; m_wdata = rq_data[w];
    end
  endtask

  initial begin
    bit found;
    model_reset();
    n_txn = 0;
    rst = 1'b1;
    ack_now = 1; rdata = rand_line();
    drive_bus();
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_enable", bus.mem_enable_o, 1'b0);
    check("rst_mem_write", bus.mem_write_o, 1'b0);
    check("rst_mem_addr", bus.mem_addr_o, '0);
    check("rst_mem_wdata", bus.mem_data_o, '0);
    check("rst_grant", bus.grant_o, 2'b00);
    check("rst_err", bus.err_o, 1'b0);
    check("rst_i_ack", bus.i_ack_o, 1'b0);
    check("rst_d_ack", bus.d_ack_o, 1'b0);
    check("rst_i_data", bus.i_data_o, '0);
    check("rst_d_data", bus.d_data_o, '0);
    #1;
    ack_now = 0;
    drive_bus();
    rst = 1'b0;

    repeat (3000) step();

    // Asynchronous reset in the middle of an I-side transaction.
    found = 0;
    for (int k = 0; k < 500 && !found; k++) begin
      step();
      if (owner == 1 && busy_cnt >= 2) found = 1;
    end
    check("rst_setup_busy_i", found, 1'b1);
    if (found) begin
      ack_now = 1;
      drive_bus();
      rst = 1'b1;
      #1;
      check("async_rst_enable", bus.mem_enable_o, 1'b0);
      check("async_rst_grant", bus.grant_o, 2'b00);
      check("async_rst_err", bus.err_o, 1'b0);
      check("async_rst_i_ack", bus.i_ack_o, 1'b0);
      check("async_rst_d_ack", bus.d_ack_o, 1'b0);
      @(posedge clk);
      #2;
      check("rst_hold_enable", bus.mem_enable_o, 1'b0);
      model_reset();
      drive_bus();
      rst = 1'b0;
    end

    repeat (1000) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
